// File: rtl/keccak_pkg.sv
// Shared constants and state type for the Keccak rate-block padder.
// Macro KECCAK_PADDER_SHA3_DOMAIN_EN selects the SHA3 domain pad byte (0x06) instead of 0x01.
package keccak_pkg;

    localparam int unsigned RATE_BITS  = 576;
    localparam int unsigned RATE_WORDS = 9;
    localparam int unsigned WORD_W     = 64;

    localparam logic [7:0] PAD_FIRST_KECCAK = 8'h01;
    localparam logic [7:0] PAD_FIRST_SHA3   = 8'h06;
    localparam logic [7:0] PAD_LAST         = 8'h80;

`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
    localparam logic [7:0] PAD_FIRST = PAD_FIRST_SHA3;
`else
    localparam logic [7:0] PAD_FIRST = PAD_FIRST_KECCAK;
`endif

    typedef enum logic [1:0] {FILL, PAD, WAIT_LAST, DONE} state_e;

endpackage

// File: rtl/padder_last_word.sv
// Builds a padded word: keeps bytes below i_byte_num, optionally inserts the first pad byte,
// and ORs in the closing 0x80 when the word is the last of the rate block.
module padder_last_word
    import keccak_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [2:0]        i_byte_num,
    input  logic              i_add_pad,
    input  logic              i_last_in_block,
    output logic [WORD_W-1:0] o_word
);

    logic [WORD_W-1:0] w_body;

    // Byte 0 sits in the most significant lane.
    for (genvar g = 0; g < 8; g++) begin : g_byte
        assign w_body[WORD_W-1-8*g -: 8] =
            (3'(g) < i_byte_num)                   ? i_word[WORD_W-1-8*g -: 8] :
            (i_add_pad && (3'(g) == i_byte_num))   ? PAD_FIRST :
                                                     8'h00;
    end

    assign o_word = w_body | {{(WORD_W-8){1'b0}}, (i_last_in_block ? PAD_LAST : 8'h00)};

endmodule

// File: rtl/keccak_padder.sv
// Collects 64-bit words into a 576-bit rate block, applies pad10*1 and hands blocks to the
// permutation via out_ready/f_ack. Build option: KECCAK_PADDER_SHA3_DOMAIN_EN (see keccak_pkg).
module keccak_padder #(
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned RATE_WORDS = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            in,
    input  logic                         in_ready,
    input  logic                         is_last,
    input  logic [2:0]                   byte_num,
    output logic                         buffer_full,
    output logic [RATE_WORDS*WORD_W-1:0] out,
    output logic                         out_ready,
    input  logic                         f_ack
);
    import keccak_pkg::*;

    if (WORD_W != 64 || RATE_WORDS * WORD_W != keccak_pkg::RATE_BITS) begin : g_param_check
        $error("keccak_padder: WORD_W must be 64 and RATE_WORDS*WORD_W must be 576");
    end

    localparam int unsigned CNT_W = $clog2(RATE_WORDS + 1);
    localparam int unsigned BLK_W = RATE_WORDS * WORD_W;

    state_e             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [BLK_W-1:0]   r_out;

    logic               w_full;
    logic               w_accept;
    logic               w_in_pad;
    logic               w_last_in_block;
    logic [WORD_W-1:0]  w_src_word;
    logic [2:0]         w_src_bytes;
    logic [WORD_W-1:0]  w_pad_word;
    logic [WORD_W-1:0]  w_fill_word;

    assign w_full          = (r_count == CNT_W'(RATE_WORDS));
    assign w_last_in_block = (r_count == CNT_W'(RATE_WORDS - 1));
    assign w_in_pad        = (r_state == PAD);
    assign w_accept        = in_ready & ~w_full & (r_state == FILL);

    // Generated PAD words are an all-zero source with no pad byte inserted.
    assign w_src_word  = w_in_pad ? '0 : in;
    assign w_src_bytes = w_in_pad ? 3'd0 : byte_num;

    padder_last_word u_last_word (
        .i_word          (w_src_word),
        .i_byte_num      (w_src_bytes),
        .i_add_pad       (~w_in_pad),
        .i_last_in_block (w_last_in_block),
        .o_word          (w_pad_word)
    );

    assign w_fill_word = is_last ? w_pad_word : in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_count <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_full) begin
                        if (f_ack) r_count <= '0;
                    end else if (w_accept) begin
                        r_out   <= {r_out[BLK_W-WORD_W-1:0], w_fill_word};
                        r_count <= r_count + 1'b1;
                        if (is_last) r_state <= w_last_in_block ? WAIT_LAST : PAD;
                    end
                end
                PAD: begin
                    r_out   <= {r_out[BLK_W-WORD_W-1:0], w_pad_word};
                    r_count <= r_count + 1'b1;
                    if (w_last_in_block) r_state <= WAIT_LAST;
                end
                WAIT_LAST: begin
                    if (w_full && f_ack) begin
                        r_count <= '0;
                        r_state <= DONE;
                    end
                end
                default: ;  // DONE: held until reset
            endcase
        end
    end

    assign out         = r_out;
    assign out_ready   = w_full;
    assign buffer_full = w_full;

endmodule

// File: tb/tb_keccak_padder.sv
// Self-checking bench for keccak_padder: byte-level pad10*1 model versus observed rate blocks.
// Honours KECCAK_PADDER_SHA3_DOMAIN_EN for the expected pad byte.
module tb_keccak_padder;

`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
    localparam logic [7:0] P = 8'h06;
`else
    localparam logic [7:0] P = 8'h01;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  w_in;
    logic         in_ready;
    logic         is_last;
    logic [2:0]   byte_num;
    logic         buffer_full;
    logic [575:0] w_out;
    logic         out_ready;
    logic         f_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   msg[$];
    logic [575:0] exp_q[$];
    logic [575:0] cap_blk0;

    always #5 clk = ~clk;

    keccak_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in          (w_in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (w_out),
        .out_ready   (out_ready),
        .f_ack       (f_ack)
    );

    // Pad the message bytes to a multiple of 72 and slice into blocks, byte 0 at the top.
    task automatic build_expected();
        int len;
        int n;
        logic [7:0] pb[];
        len = msg.size();
        n   = (len / 72 + 1) * 72;
        pb  = new[n];
        for (int i = 0; i < n; i++) pb[i] = (i < len) ? msg[i] : 8'h00;
        pb[len]   = pb[len] | P;
        pb[n - 1] = pb[n - 1] | 8'h80;
        exp_q.delete();
        for (int k = 0; k < n / 72; k++) begin
            logic [575:0] blk;
            for (int j = 0; j < 72; j++) blk[575 - 8 * j -: 8] = pb[72 * k + j];
            exp_q.push_back(blk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_ready = 1'b0; is_last = 1'b0; byte_num = 3'd0; f_ack = 1'b0; w_in = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_message(input int ack_fixed, input string name);
        int len, nwords, wi, blk, nblk, wait_cnt, cyc, last_acc, exp_lat;
        logic [63:0] word;
        build_expected();
        len = msg.size(); nwords = len / 8 + 1; wi = 0; blk = 0; nblk = exp_q.size();
        wait_cnt = -1; cyc = 0; last_acc = -1; exp_lat = 9 - (len / 8) % 9;
        while (blk < nblk && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            f_ack = 1'b0;
            if (out_ready === 1'b1) begin
                if (wait_cnt < 0) begin
                    n_cmp++;
                    if (w_out !== exp_q[blk]) begin
                        n_err++;
                        $display("FAIL %s block%0d out: got %h want %h", name, blk, w_out, exp_q[blk]);
                    end
                    if (blk == 0) cap_blk0 = w_out;
                    if (blk == nblk - 1 && last_acc >= 0) begin
                        n_cmp++;
                        if (cyc - last_acc != exp_lat) begin
                            n_err++;
                            $display("FAIL %s latency: got %0d want %0d", name, cyc - last_acc, exp_lat);
                        end
                    end
                    wait_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 4));
                end else begin
                    n_cmp++;
                    if (w_out !== exp_q[blk] || buffer_full !== 1'b1) begin
                        n_err++;
                        $display("FAIL %s hold block%0d: full=%b got %h want %h", name, blk,
                                 buffer_full, w_out, exp_q[blk]);
                    end
                end
                if (wait_cnt == 0) begin
                    f_ack = 1'b1; blk++; wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                f_ack = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
            end
            if (wi < nwords) begin
                for (int b = 0; b < 8; b++)
                    word[63 - 8 * b -: 8] = (8 * wi + b < len) ? msg[8 * wi + b] : 8'($urandom);
                w_in     = word;
                is_last  = (wi == nwords - 1);
                byte_num = is_last ? 3'(len % 8) : 3'($urandom);
                in_ready = ($urandom_range(0, 3) != 0);
                if (in_ready && buffer_full !== 1'b1) begin
                    if (is_last) last_acc = cyc;
                    wi++;
                end
            end else begin
                w_in = {$urandom, $urandom}; is_last = 1'($urandom);
                byte_num = 3'($urandom); in_ready = 1'($urandom);
            end
        end
        if (blk < nblk) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: got %0d blocks want %0d", name, blk, nblk);
        end
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (out_ready !== 1'b0 || buffer_full !== 1'b0) begin
                n_err++;
                $display("FAIL %s done: got ready=%b full=%b want 0 0", name, out_ready, buffer_full);
            end
            f_ack = 1'($urandom); in_ready = 1'b1; is_last = 1'($urandom);
            byte_num = 3'($urandom); w_in = {$urandom, $urandom};
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (w_out !== '0 || out_ready !== 1'b0 || buffer_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got ready=%b full=%b out=%h want all 0", out_ready, buffer_full, w_out);
        end
    endtask

    task automatic test_empty();
        do_reset();
        msg.delete();
        run_message(0, "empty");
        n_cmp++;
        if (cap_blk0[575:512] !== {P, 56'h0} || cap_blk0[511:64] !== '0 ||
            cap_blk0[63:0] !== 64'h80) begin
            n_err++;
            $display("FAIL empty words: got %h want first %h last 80", cap_blk0, {P, 56'h0});
        end
    endtask

    task automatic test_three_byte();
        do_reset();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_message(-1, "abc");
        n_cmp++;
        if (cap_blk0[575:512] !== {24'h616263, P, 32'h0} || cap_blk0[63:0] !== 64'h80) begin
            n_err++;
            $display("FAIL abc words: got %h / %h want %h / 80", cap_blk0[575:512], cap_blk0[63:0],
                     {24'h616263, P, 32'h0});
        end
    endtask

    task automatic test_71_byte();
        do_reset();
        msg.delete();
        for (int i = 0; i < 71; i++) msg.push_back(8'($urandom));
        run_message(-1, "len71");
        n_cmp++;
        if (cap_blk0[7:0] !== (8'h80 | P)) begin
            n_err++;
            $display("FAIL len71 merged byte: got %h want %h", cap_blk0[7:0], 8'h80 | P);
        end
    endtask

    task automatic test_multi_block();
        do_reset();
        msg.delete();
        for (int i = 0; i < 144; i++) msg.push_back(8'($urandom));
        run_message(5, "multi");
    endtask

    task automatic test_reset_in_pad();
        do_reset();
        w_in = {$urandom, $urandom}; in_ready = 1'b1; is_last = 1'b1; byte_num = 3'd0;
        @(negedge clk);
        in_ready = 1'b0; is_last = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (w_out[255:192] !== {P, 56'h0} || w_out[191:0] !== '0 || out_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pad progress: got %h ready=%b want %h", w_out[255:0], out_ready, {P, 56'h0});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (w_out !== '0 || out_ready !== 1'b0 || buffer_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset in pad: got ready=%b full=%b out=%h want all 0",
                     out_ready, buffer_full, w_out);
        end
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
        run_message(-1, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            do_reset();
            msg.delete();
            for (int i = 0, n = int'($urandom_range(0, 220)); i < n; i++) msg.push_back(8'($urandom));
            run_message(-1, "random");
        end
    endtask

    initial begin
        reset = 1'b1; in_ready = 1'b0; is_last = 1'b0; byte_num = 3'd0; f_ack = 1'b0; w_in = '0;
        test_reset();
        test_empty();
        test_three_byte();
        test_71_byte();
        test_multi_block();
        test_reset_in_pad();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
